// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and its
// companion 1011 sequence detector.
//   seq_state_e : transmitter FSM states
//   SEQ_1011    : the pattern the detector looks for, default burst pattern
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: on an accepted start it captures a pattern,
// repeat count and gap length, then shifts the pattern out MSB-first, one bit
// per clock, with gap idle cycles between repetitions.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : burst request, honoured only in IDLE
//   use_def      : 1 selects DEF_PATTERN, 0 selects pattern_i
//   pattern_i    : pattern, count_i : repetitions, gap_i : idle bits between
//   abort        : ends a running burst at once, no done pulse
//   x, x_valid   : serial data and its qualifier
//   sof          : first bit of each repetition
//   busy, done   : not-idle flag, normal-completion pulse
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned          PAT_W       = 4,
  parameter logic [PAT_W-1:0]     DEF_PATTERN = PAT_W'(SEQ_1011),
  parameter int unsigned          CNT_W       = 8,
  parameter int unsigned          GAP_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [PAT_W-1:0] shadow_q, shadow_d;
  logic             x_d, x_valid_d, sof_d, busy_d, done_d;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      reps_q    <= '0;
      gap_cnt_q <= '0;
      gap_len_q <= '0;
      shadow_q  <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      sof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      reps_q    <= reps_d;
      gap_cnt_q <= gap_cnt_d;
      gap_len_q <= gap_len_d;
      shadow_q  <= shadow_d;
      x         <= x_d;
      x_valid   <= x_valid_d;
      sof       <= sof_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state, counter updates and output decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    reps_d    = reps_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    shadow_d  = shadow_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          shadow_d  = use_def ? DEF_PATTERN : pattern_i;
          reps_d    = count_i;
          gap_len_d = gap_i;
          idx_d     = IDX_TOP;
          state_d   = (count_i == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (idx_q == '0) begin
          // reps_q counts the repetition being sent, so 1 means last one
          reps_d = reps_q - CNT_W'(1);
          idx_d  = IDX_TOP;
          if (reps_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (gap_len_q != '0) begin
            gap_cnt_d = gap_len_q;
            state_d   = GAP;
          end else begin
            state_d = SEND;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          idx_d   = IDX_TOP;
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    // Outputs reflect the state being entered so they are valid right after the edge
    x_valid_d = (state_d == SEND);
    x_d       = x_valid_d ? shadow_d[idx_d] : 1'b0;
    sof_d     = x_valid_d && (idx_d == IDX_TOP);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: on a start request it loads a PAT_W-bit pattern, repeat count and inter-frame gap, then drives the pattern MSB-first onto a one-bit serial line, one bit per clock. It is the driving end of the serial line monitored by the team's 1011 sequence detector. It replaces hand-written stimulus in that detector's bench, and it is also a synthesizable pattern source on chip. Its serial output wires directly to the detector's `x` input.

## Interface
One clock `clk`; reset `rst` is synchronous and active-high.

- PAT_W, 4, pattern width in bits (≥2)
- DEF_PATTERN, 4'b1011, pattern used when `use_def` is 1
- CNT_W, 8, width of repeat count
- GAP_W, 4, width of gap length
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a burst; accepted only in IDLE
- use_def  in  1  sampled with start; 1 selects DEF_PATTERN, 0 selects pattern_i
- pattern_i  in  PAT_W  pattern, sampled on accepted start
- count_i  in  CNT_W  number of repetitions, sampled on accepted start
- gap_i  in  GAP_W  idle zero-bits between repetitions, sampled on accepted start
- abort  in  1  terminate burst immediately
- x  out  1  serial data
- x_valid  out  1  high while x carries a pattern bit
- sof  out  1  one-cycle pulse coincident with the first bit of each repetition
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on normal burst completion

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: when start=1, latch the pattern, count and gap.
  - If count_i=0, go to DONE: no bits are sent, only the done pulse.
  - Otherwise go to SEND with bit index PAT_W-1 and remaining reps = count_i.
- SEND: x = shadow pattern[idx], x_valid=1, sof=1 when idx=PAT_W-1. Decrement idx every cycle.
- At idx=0, decrement the rep counter:
  - remaining reps now 0 → DONE;
  - else gap≠0 → GAP;
  - else → SEND again with idx=PAT_W-1. Repetitions are back-to-back, with no idle cycle between them.
- GAP: x=0, x_valid=0 for exactly gap cycles, then SEND with idx=PAT_W-1.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored. New inputs are never re-sampled mid-burst.
- abort has priority over all transitions except rst.
  - In SEND, GAP or DONE: next state is IDLE, with outputs as in IDLE and no done pulse.
  - abort in IDLE is a no-op. If start and abort are both asserted in IDLE, abort wins and start is dropped.
- Rep counter is CNT_W bits: count_i = 2^CNT_W-1 sends exactly that many repetitions, with no wrap.
- Gap counter is GAP_W bits: gap_i=0 means back-to-back repetitions.

## Timing
- All outputs are registered. Reset values: x=0, x_valid=0, sof=0, busy=0, done=0; state IDLE; all counters 0.
- Start accepted at edge N → first pattern bit on x from edge N+1; busy=1 from edge N+1.
- Burst length in cycles = count·PAT_W + (count-1)·gap. done is high the cycle after the last bit; busy falls with done.
- Earliest next accepted start is the cycle after done, i.e. start sampled high while done=1 is ignored.
- rst mid-burst: all outputs return to reset values at the next edge, same as power-up.

## Structure
- Package `seq_pkg`:
  - state enum `seq_state_e` (IDLE, SEND, GAP, DONE);
  - constant `SEQ_1011 = 4'b1011`, shared with the detector and its bench.
- Single module, no sub-modules. A counter block is not worth a separate module at this size.

## Test plan
- Default pattern, count=2, gap=1, then rst released:
  - x = 1,0,1,1,0,1,0,1,1 over 9 cycles;
  - sof at cycles 1 and 6; done at cycle 10;
  - looped into the 1011 detector, gives detection count 2.
- pattern_i=4'b0110, use_def=0, count=3, gap=0 → x = 0110 0110 0110 contiguous, x_valid high for 12 cycles, sof every 4th cycle.
- count=0 → no x_valid ever, done one cycle after start, busy high exactly 1 cycle.
- abort asserted on the 3rd bit of the 2nd repetition → next cycle x=0, busy=0, no done pulse; a subsequent start runs normally.
- start pulsed mid-burst and while done=1 → ignored; burst length unchanged; only one done.
- rst asserted during GAP → all outputs 0 next edge; state IDLE; fresh start with count=1 emits exactly 4 bits.
